uart_report_formatter: RTL

//  Parametrised multi-channel UART text reporter. Takes a snapshot of CHANNELS packed BCD readings and

---
 rtl/uart_report_formatter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_report_formatter.sv
// -----------------------------------------------------------------------------
// uart_report_formatter
//
// Multi-channel ASCII line reporter. A frame captures a snapshot of CHANNELS
// packed BCD readings, then streams one text line per channel to a byte-wide
// UART transmitter over a valid/ready handshake:
//
//   "Vnn - dddd U\r\n"   (nn = 01..CHANNELS, dddd = DIGITS BCD digits, U = UNIT)
//
// Frames start on the start input, on a start queued while a frame was running,
// or periodically after PERIOD idle cycles (PERIOD = 0 disables auto frames).
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous reset, active low
//   data_in    : packed BCD, channel k = data_in[k*DIGITS*4 +: DIGITS*4], MS digit first
//   start      : frame request, level sampled every clock
//   tx_ready   : transmitter accepts tx_data this cycle
//   tx_data    : ASCII byte offered to the transmitter
//   tx_valid   : tx_data valid; a byte moves on a clock edge with tx_valid && tx_ready
//   busy       : high from LOAD through DONE
//   frame_done : one-cycle pulse after the last byte of a frame has moved
// -----------------------------------------------------------------------------
module uart_report_formatter #(
  parameter int         CHANNELS = 13,
  parameter int         DIGITS   = 4,
  parameter int         PERIOD   = 100_000_000,
  parameter logic [7:0] UNIT     = 8'h56
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*DIGITS*4-1:0] data_in,
  input  logic                         start,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int   LINE_LEN = DIGITS + 10;
  localparam int   DATA_W   = CHANNELS * DIGITS * 4;
  localparam int   TIMER_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic AUTO_EN  = (PERIOD != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t               state, state_d;
  logic [TIMER_W-1:0]   timer, timer_d;
  logic                 pending, pending_d;
  logic [DATA_W-1:0]    snap;
  logic                 snap_load;
  logic [6:0]           ch_idx, ch_idx_d;
  logic [4:0]           byte_idx, byte_idx_d;
  logic [7:0]           tx_data_d;
  logic                 tx_valid_d;
  logic                 busy_d;
  logic                 frame_done_d;
  logic                 timer_hit;
  logic                 last_of_line;
  logic                 last_of_frame;

  // Character at position pos of the line for channel ch, taken from the
  // snapshot s. Label is ch+1 printed as two decimal digits.
  function automatic logic [7:0] line_byte(input logic [6:0]        ch,
                                           input logic [4:0]        pos,
                                           input logic [DATA_W-1:0] s);
    int         label;
    int         p;
    int         dig;
    logic [3:0] nib;
    label = int'(ch) + 1;
    p     = int'(pos);
    line_byte = 8'h20;
    if (p == 0) begin
      line_byte = 8'h56;
    end else if (p == 1) begin
      line_byte = 8'h30 + 8'(label / 10);
    end else if (p == 2) begin
      line_byte = 8'h30 + 8'(label % 10);
    end else if (p == 4) begin
      line_byte = 8'h2D;
    end else if (p >= 6 && p < 6 + DIGITS) begin
      dig = p - 6;
      // Most significant digit sits in the top nibble of the channel field.
      nib = 4'(s >> (int'(ch) * DIGITS * 4 + (DIGITS - 1 - dig) * 4));
      line_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : 8'h3F;
    end else if (p == DIGITS + 7) begin
      line_byte = UNIT;
    end else if (p == DIGITS + 8) begin
      line_byte = 8'h0D;
    end else if (p == DIGITS + 9) begin
      line_byte = 8'h0A;
    end
  endfunction

  assign timer_hit     = AUTO_EN && (timer == TIMER_W'(PERIOD - 1));
  assign last_of_line  = (byte_idx == 5'(LINE_LEN - 1));
  assign last_of_frame = last_of_line && (ch_idx == 7'(CHANNELS - 1));

  // NOTE: every signal driven here gets a default before the case so that no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d      = state;
    timer_d      = timer;
    pending_d    = pending;
    ch_idx_d     = ch_idx;
    byte_idx_d   = byte_idx;
    tx_data_d    = tx_data;
    tx_valid_d   = tx_valid;
    busy_d       = busy;
    frame_done_d = 1'b0;
    snap_load    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start || pending || timer_hit) begin
          state_d   = S_LOAD;
          timer_d   = '0;
          pending_d = 1'b0;
          busy_d    = 1'b1;
        end else if (AUTO_EN) begin
          timer_d = timer + 1'b1;
        end
      end

      S_LOAD: begin
        snap_load  = 1'b1;
        ch_idx_d   = '0;
        byte_idx_d = '0;
        tx_data_d  = line_byte(7'd0, 5'd0, data_in);
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
        if (start) pending_d = 1'b1;
      end

      S_SEND: begin
        if (start) pending_d = 1'b1;
        if (tx_valid && tx_ready) begin
          if (last_of_frame) begin
            tx_valid_d   = 1'b0;
            frame_done_d = 1'b1;
            state_d      = S_DONE;
          end else if (last_of_line) begin
            ch_idx_d   = ch_idx + 7'd1;
            byte_idx_d = '0;
            tx_data_d  = line_byte(ch_idx + 7'd1, 5'd0, snap);
          end else begin
            byte_idx_d = byte_idx + 5'd1;
            tx_data_d  = line_byte(ch_idx, byte_idx + 5'd1, snap);
          end
        end
      end

      S_DONE: begin
        if (start) pending_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      pending    <= 1'b0;
      ch_idx     <= '0;
      byte_idx   <= '0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      pending    <= pending_d;
      ch_idx     <= ch_idx_d;
      byte_idx   <= byte_idx_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

  // NOTE: the snapshot is plain data storage, only read after LOAD has written
  // it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (snap_load) snap <= data_in;
  end

endmodule
